keypad_entry: RTL and testbench

Input-side companion of the seven-segment display path: scans a 4x4 active-low matrix keypad, debounces presses, converts each accepted key to a 4-bit hex code and shifts it into a 32-bit entry register. The entry register drives the CPU's 32-bit input word and can be routed back to the display driver for echo. One key is accepted per press/release cycle. Auto-repeat is not supported.

---
 rtl/keypad_entry_if.sv | 14 +
 rtl/keypad_entry.sv | 144 ++++++++++++++
 tb/tb_keypad_entry.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Keypad-side and CPU-side signals of the keypad entry block.
// slave is the keypad_entry view; master is the keypad/CPU view.
interface keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clr;
    logic [31:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    modport master (output row, clr, input col, value, key_code, key_valid, key_down);
    modport slave  (input row, clr, output col, value, key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_entry.sv
// 4x4 active-low keypad scanner with debounce; accepted keys shift a hex
// digit into a 32-bit entry register.
module keypad_entry #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_entry_if.slave bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {ST_SCAN, ST_DEB, ST_HELD} state_t;

    // Lowest low row index wins when several rows are pressed in one column.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

    state_t          state, state_n;
    logic [3:0]      row_m, row_s;
    logic [DW-1:0]   div;
    logic            tick;
    logic [1:0]      ci, ci_n;
    logic [1:0]      r, r_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   rcnt, rcnt_n;
    logic [CW-1:0]   rcnt_inc;
    logic            accept;
    logic [3:0]      code;
    logic [31:0]     value;
    logic [3:0]      key_code;
    logic            key_valid;
    logic            key_down;

    assign tick     = (div == DW'(SCAN_DIV - 1));
    assign code     = {r, ci};
    assign rcnt_inc = rcnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
            div   <= '0;
        end else begin
            row_m <= bus.row;
            row_s <= row_m;
            div   <= tick ? '0 : div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SCAN;
            ci    <= '0;
            r     <= '0;
            cnt   <= '0;
            rcnt  <= '0;
        end else begin
            state <= state_n;
            ci    <= ci_n;
            r     <= r_n;
            cnt   <= cnt_n;
            rcnt  <= rcnt_n;
        end
    end

    // Every decision is taken on tick; between ticks the state holds.
    always_comb begin
        state_n = state;
        ci_n    = ci;
        r_n     = r;
        cnt_n   = cnt;
        rcnt_n  = rcnt;
        accept  = 1'b0;
        if (tick) begin
            unique case (state)
                ST_SCAN: begin
                    if (row_s != 4'hF) begin
                        r_n     = low_row(row_s);
                        cnt_n   = CW'(1);
                        state_n = ST_DEB;
                    end else begin
                        ci_n = ci + 1'b1;
                    end
                end
                ST_DEB: begin
                    if (!row_s[r]) begin
                        if (cnt == CW'(DEBOUNCE)) begin
                            accept  = 1'b1;
                            rcnt_n  = '0;
                            state_n = ST_HELD;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else begin
                        ci_n    = ci + 1'b1;
                        state_n = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (row_s[r]) begin
                        if (rcnt_inc == CW'(DEBOUNCE)) begin
                            rcnt_n  = '0;
                            ci_n    = ci + 1'b1;
                            state_n = ST_SCAN;
                        end else begin
                            rcnt_n = rcnt_inc;
                        end
                    end else begin
                        rcnt_n = '0;
                    end
                end
                default: state_n = ST_SCAN;
            endcase
        end
    end

    // Registered outputs; clear wins over the old contents but keeps a new digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= accept;
            key_down  <= (state_n == ST_HELD);
            if (accept) key_code <= code;
            if (bus.clr)     value <= accept ? {28'h0, code} : 32'h0;
            else if (accept) value <= {value[27:0], code};
        end
    end

    assign bus.col       = ~(4'b0001 << ci);
    assign bus.value     = value;
    assign bus.key_code  = key_code;
    assign bus.key_valid = key_valid;
    assign bus.key_down  = key_down;
endmodule

// File: tb/tb_keypad_entry.sv
// Randomized bench for keypad_entry: a key-matrix model drives the rows and a
// digit-queue scoreboard predicts every accepted key and the entry register.
module tb_keypad_entry;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int TICK     = SCAN_DIV;

    logic clk;
    logic rst;
    logic [15:0] pressed;
    logic [3:0]  row_drv;
    logic [3:0]  exp_q[$];
    logic [31:0] mv;
    int n_cmp, n_bad, kv_count;

    keypad_entry_if bus ();

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_drv = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (!bus.col[cc] && pressed[4*rr+cc]) row_drv[rr] = 1'b0;
    end
    assign bus.row = row_drv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: each pulse must match the oldest outstanding key.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mv = 32'h0;
        end else if (bus.key_valid) begin
            kv_count++;
            chk("kv_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [3:0] c;
                c = exp_q.pop_front();
                mv = bus.clr ? {28'h0, c} : ((mv << 4) | {28'h0, c});
                chk("kv_code", 32'(bus.key_code), 32'(c));
                chk("kv_value", bus.value, mv);
                chk("kv_down", 32'(bus.key_down), 32'd1);
            end
        end else if (bus.clr) begin
            mv = 32'h0;
        end
    end

    task automatic wait_col(input logic [3:0] target);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.col == target) ok = 1;
        end
        chk("col_reach", 32'(ok), 32'd1);
    endtask

    task automatic release_all();
        bit ok;
        pressed = '0;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (!bus.key_down) ok = 1;
        end
        chk("release_done", 32'(ok), 32'd1);
        repeat (2*TICK) @(negedge clk);
    endtask

    task automatic press_key(input int code, input int extra_ticks);
        int base;
        bit seen;
        base = kv_count;
        exp_q.push_back(code[3:0]);
        pressed[code[3:0]] = 1'b1;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (kv_count != base) seen = 1;
        end
        chk("kv_seen", 32'(seen), 32'd1);
        repeat (extra_ticks*TICK) @(negedge clk);
        chk("one_kv_per_press", 32'(kv_count - base), 32'd1);
        release_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, lat, changes;
        logic [3:0] col0;
        n_cmp = 0; n_bad = 0; kv_count = 0;
        mv = 32'h0;
        pressed = '0;
        bus.clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_col", 32'(bus.col), 32'h0000000E);
        chk("rst_value", bus.value, 32'h0);
        chk("rst_code", 32'(bus.key_code), 32'h0);
        chk("rst_valid", 32'(bus.key_valid), 32'h0);
        chk("rst_down", 32'(bus.key_down), 32'h0);
        rst = 1'b0;

        // Single press of key 9 (row 2, column 1) with latency measurement.
        wait_col(4'b1110);
        base = kv_count;
        exp_q.push_back(4'h9);
        pressed[9] = 1'b1;
        wait_col(4'b1101);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.key_valid) begin lat = i; break; end
        end
        chk("single_latency", 32'(lat), 32'(DEBOUNCE*SCAN_DIV + 4));
        chk("single_code", 32'(bus.key_code), 32'h9);
        chk("single_value", bus.value, 32'h00000009);
        repeat (6*TICK) @(negedge clk);
        pressed = '0;
        repeat (8) @(negedge clk);
        chk("kd_hold_after_release", 32'(bus.key_down), 32'd1);
        repeat (12) @(negedge clk);
        chk("kd_fall", 32'(bus.key_down), 32'd0);
        chk("single_count", 32'(kv_count - base), 32'd1);
        repeat (2*TICK) @(negedge clk);

        // Bounce: 2 ticks low, 1 tick high, then a real hold on key 3.
        wait_col(4'b1011);
        wait_col(4'b0111);
        base = kv_count;
        pressed[3] = 1'b1;
        repeat (2*TICK) @(negedge clk);
        pressed[3] = 1'b0;
        repeat (TICK) @(negedge clk);
        chk("bounce_no_kv", 32'(kv_count - base), 32'd0);
        press_key(3, 2);
        chk("bounce_code", 32'(bus.key_code), 32'h3);

        // Nine-digit entry then clear.
        for (int k = 1; k <= 9; k++) press_key(k, 1);
        chk("nine_value", bus.value, 32'h23456789);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        chk("clr_value", bus.value, 32'h0);
        chk("clr_code", 32'(bus.key_code), 32'h9);

        // Rows 1 and 3 at column 0, with clr landing on the accept cycle.
        wait_col(4'b1011);
        wait_col(4'b0111);
        exp_q.push_back(4'h4);
        pressed[4] = 1'b1;
        pressed[12] = 1'b1;
        wait_col(4'b1110);
        repeat (DEBOUNCE*SCAN_DIV + 3) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        chk("coinc_valid", 32'(bus.key_valid), 32'd1);
        chk("coinc_code", 32'(bus.key_code), 32'h4);
        chk("coinc_value", bus.value, 32'h00000004);
        release_all();

        // Long hold: one key, column frozen.
        base = kv_count;
        exp_q.push_back(4'h6);
        pressed[6] = 1'b1;
        for (int i = 0; i < 300 && kv_count == base; i++) @(negedge clk);
        col0 = bus.col;
        changes = 0;
        for (int i = 0; i < 100*TICK; i++) begin
            @(negedge clk);
            if (bus.col != col0) changes++;
        end
        chk("hold_col_frozen", 32'(changes), 32'd0);
        chk("hold_one_kv", 32'(kv_count - base), 32'd1);
        chk("hold_down", 32'(bus.key_down), 32'd1);
        release_all();

        // Random keys, some preceded by a glitch too short to be accepted.
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                base = kv_count;
                pressed[$urandom_range(15, 0)] = 1'b1;
                repeat ($urandom_range(DEBOUNCE*SCAN_DIV, 1)) @(negedge clk);
                pressed = '0;
                repeat (2*TICK) @(negedge clk);
                chk("glitch_no_kv", 32'(kv_count - base), 32'd0);
            end
            press_key(int'($urandom_range(15, 0)), int'($urandom_range(8, 0)));
        end

        // Reset while a key is held.
        press_key(10, 0);
        exp_q.push_back(4'hA);
        pressed[10] = 1'b1;
        base = kv_count;
        for (int i = 0; i < 300 && !bus.key_down; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_col", 32'(bus.col), 32'h0000000E);
        chk("midrst_value", bus.value, 32'h0);
        chk("midrst_down", 32'(bus.key_down), 32'h0);
        chk("midrst_valid", 32'(bus.key_valid), 32'h0);
        chk("midrst_code", 32'(bus.key_code), 32'h0);
        pressed = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10*TICK) @(negedge clk);
        chk("midrst_no_kv", 32'(kv_count - base), 32'd1);
        chk("midrst_value_after", bus.value, 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
